// File: rtl/grf_wb_arbiter_if.sv
// Purpose: bundles the WB, long-latency, decode-read and GRF write-port signals of the arbiter.
// Latency: none; wiring only.
// Backpressure: lu_ready flows slave->master; the WB path is never back-pressured.
interface grf_wb_arbiter_if #(
  parameter int AW = 2
) ();
  logic          wb_valid;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;
  logic          lu_valid;
  logic          lu_ready;
  logic [4:0]    lu_addr;
  logic [31:0]   lu_data;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic          reg_write;
  logic [4:0]    write_addr;
  logic [31:0]   write_data;
  logic          bypass_rs_grf;
  logic          bypass_rt_grf;
  logic          pending_rs;
  logic          pending_rt;
  logic [AW:0]   fifo_level;

  // Arbiter side
  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  lu_valid, lu_addr, lu_data,
    input  rs, rt,
    output lu_ready,
    output reg_write, write_addr, write_data,
    output bypass_rs_grf, bypass_rt_grf,
    output pending_rs, pending_rt,
    output fifo_level
  );

  // Pipeline side
  modport master (
    output wb_valid, wb_addr, wb_data,
    output lu_valid, lu_addr, lu_data,
    output rs, rt,
    input  lu_ready,
    input  reg_write, write_addr, write_data,
    input  bypass_rs_grf, bypass_rt_grf,
    input  pending_rs, pending_rt,
    input  fifo_level
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// Purpose: single GRF write port shared by in-order WB results and a queued long-latency stream.
// Latency: WB -> write port 1 cycle; long-latency accept -> write port >= 2 cycles.
// Backpressure: lu_ready drops when the queue is full or in reset; WB always wins the slot.
module grf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            clk,
  input  logic            reset,
  grf_wb_arbiter_if.slave bus
);

  typedef struct packed {
    logic        live;
    logic [4:0]  addr;
    logic [31:0] data;
  } lu_ent_t;

  lu_ent_t       fifo [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   level;

  logic          full;
  logic          empty;
  logic          wb_sel;
  logic          push;
  logic          pop;
  logic          issue;
  lu_ent_t       head;

  logic          rw_q;
  logic [4:0]    wa_q;
  logic [31:0]   wd_q;
  logic          hit_rs;
  logic          hit_rt;

  assign full   = (level == (AW+1)'(DEPTH));
  assign empty  = (level == '0);
  assign head   = fifo[rd_ptr];

  // A WB result to r0 is a no-op and leaves the slot free for the queue.
  assign wb_sel = bus.wb_valid && (bus.wb_addr != 5'd0);

  // No push-through: a full queue refuses even if it pops this cycle.
  assign bus.lu_ready = !full && !reset;

  // r0 results complete the handshake but never occupy a slot.
  assign push  = bus.lu_valid && bus.lu_ready && (bus.lu_addr != 5'd0);

  // Killed heads still consume the free slot so the queue keeps moving.
  assign pop   = !wb_sel && !empty;
  assign issue = pop && head.live;

  // Queue storage: pop retires the head, WB kills older same-address entries, push appends live.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo[i].live <= 1'b0;
      end
    end else begin
      if (pop) begin
        fifo[rd_ptr].live <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      if (wb_sel) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (fifo[i].addr == bus.wb_addr) begin
            fifo[i].live <= 1'b0;
          end
        end
      end
      // Applied last so an entry pushed alongside a matching WB stays live.
      if (push) begin
        fifo[wr_ptr] <= '{live: 1'b1, addr: bus.lu_addr, data: bus.lu_data};
        wr_ptr       <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Write port: latch the winner of this cycle's slot; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_q <= 1'b0;
      wa_q <= 5'd0;
      wd_q <= 32'd0;
    end else begin
      rw_q <= wb_sel || issue;
      if (wb_sel) begin
        wa_q <= bus.wb_addr;
        wd_q <= bus.wb_data;
      end else if (issue) begin
        wa_q <= head.addr;
        wd_q <= head.data;
      end
    end
  end

  // Scoreboard: any live queued write to a decode source register means stall.
  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo[i].live && (fifo[i].addr == bus.rs)) hit_rs = 1'b1;
      if (fifo[i].live && (fifo[i].addr == bus.rt)) hit_rt = 1'b1;
    end
  end

  assign bus.reg_write     = rw_q;
  assign bus.write_addr    = wa_q;
  assign bus.write_data    = wd_q;
  assign bus.bypass_rs_grf = rw_q && (wa_q == bus.rs) && (bus.rs != 5'd0);
  assign bus.bypass_rt_grf = rw_q && (wa_q == bus.rt) && (bus.rt != 5'd0);
  assign bus.pending_rs    = hit_rs && (bus.rs != 5'd0);
  assign bus.pending_rt    = hit_rt && (bus.rt != 5'd0);
  assign bus.fifo_level    = level;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the write-port arbiter.
module tb_grf_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct packed {
    logic        live;
    logic [4:0]  addr;
    logic [31:0] data;
  } m_ent_t;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  logic last_acc;
  int   k;

  // Model state
  m_ent_t      q[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  grf_wb_arbiter_if #(.AW(AW)) bus ();

  grf_wb_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // One clock: compare all outputs at the falling edge, advance the model, cross the rising edge.
  task automatic cycle();
    logic   exp_rdy;
    logic   p_rs;
    logic   p_rt;
    logic   wbw;
    m_ent_t h;
    @(negedge clk);
    exp_rdy = !reset && (q.size() < DEPTH);
    p_rs = 1'b0;
    p_rt = 1'b0;
    foreach (q[i]) begin
      if (q[i].live && q[i].addr == bus.rs) p_rs = 1'b1;
      if (q[i].live && q[i].addr == bus.rt) p_rt = 1'b1;
    end
    p_rs = p_rs && (bus.rs != 5'd0);
    p_rt = p_rt && (bus.rt != 5'd0);
    chk("lu_ready",   32'(bus.lu_ready),   32'(exp_rdy));
    chk("fifo_level", 32'(bus.fifo_level), 32'(q.size()));
    chk("reg_write",  32'(bus.reg_write),  32'(m_we));
    chk("write_addr", 32'(bus.write_addr), 32'(m_wa));
    chk("write_data", bus.write_data,      m_wd);
    chk("bypass_rs",  32'(bus.bypass_rs_grf), 32'(m_we && m_wa == bus.rs && bus.rs != 5'd0));
    chk("bypass_rt",  32'(bus.bypass_rt_grf), 32'(m_we && m_wa == bus.rt && bus.rt != 5'd0));
    chk("pending_rs", 32'(bus.pending_rs), 32'(p_rs));
    chk("pending_rt", 32'(bus.pending_rt), 32'(p_rt));
    last_acc = bus.lu_valid && exp_rdy;
    if (reset) begin
      q.delete();
      m_we = 1'b0;
      m_wa = 5'd0;
      m_wd = 32'd0;
    end else begin
      wbw  = bus.wb_valid && (bus.wb_addr != 5'd0);
      m_we = 1'b0;
      if (wbw) begin
        foreach (q[i]) if (q[i].addr == bus.wb_addr) q[i].live = 1'b0;
        m_we = 1'b1;
        m_wa = bus.wb_addr;
        m_wd = bus.wb_data;
      end else if (q.size() > 0) begin
        h = q.pop_front();
        if (h.live) begin
          m_we = 1'b1;
          m_wa = h.addr;
          m_wd = h.data;
        end
      end
      if (last_acc && bus.lu_addr != 5'd0)
        q.push_back('{live: 1'b1, addr: bus.lu_addr, data: bus.lu_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
    bus.lu_valid = 1'b0; bus.lu_addr = 5'd0; bus.lu_data = 32'd0;
    bus.rs = 5'd0; bus.rt = 5'd0;
  endtask

  initial begin
    n_pass = 0; n_total = 0; last_acc = 1'b0; k = 0;
    m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    cycle();
    reset = 1'b0;
    cycle();

    // 1: WB write lands on the port one cycle later, bypass flags it
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234; bus.rs = 5'd5;
    cycle();
    bus.wb_valid = 1'b0;
    #1;
    chk("t1_we",     32'(bus.reg_write), 32'd1);
    chk("t1_addr",   32'(bus.write_addr), 32'd5);
    chk("t1_data",   bus.write_data, 32'h1234);
    chk("t1_bypass", 32'(bus.bypass_rs_grf), 32'd1);
    cycle();

    // 2: LU write with WB idle shows up two cycles after accept
    bus.rs = 5'd0;
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd7; bus.lu_data = 32'hAA; bus.rt = 5'd7;
    cycle();
    bus.lu_valid = 1'b0;
    #1;
    chk("t2_pending", 32'(bus.pending_rt), 32'd1);
    cycle();
    chk("t2_we",   32'(bus.reg_write), 32'd1);
    chk("t2_addr", 32'(bus.write_addr), 32'd7);
    chk("t2_data", bus.write_data, 32'hAA);
    chk("t2_pend_clr", 32'(bus.pending_rt), 32'd0);
    bus.rt = 5'd0;
    cycle();

    // 3: fill the queue under continuous WB, then drain in order
    k = 0;
    for (int i = 0; i < 6; i++) begin
      bus.wb_valid = 1'b1; bus.wb_addr = 5'(20 + i); bus.wb_data = 32'(i);
      bus.lu_valid = 1'b1; bus.lu_addr = 5'(10 + k); bus.lu_data = 32'h100 + 32'(k);
      cycle();
      if (last_acc) k++;
    end
    chk("t3_level", 32'(bus.fifo_level), 32'd4);
    chk("t3_ready", 32'(bus.lu_ready), 32'd0);
    bus.wb_valid = 1'b0;
    cycle();
    chk("t3_first_we",   32'(bus.reg_write), 32'd1);
    chk("t3_first_addr", 32'(bus.write_addr), 32'd10);
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (last_acc) bus.lu_valid = 1'b0;
    end
    chk("t3_drained", 32'(bus.fifo_level), 32'd0);

    // 4: WAW kill of a queued entry
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h33;
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd9; bus.lu_data = 32'h99;
    cycle();
    bus.lu_valid = 1'b0;
    bus.wb_addr = 5'd9; bus.wb_data = 32'h55; bus.rs = 5'd9;
    #1;
    chk("t4_pend_before", 32'(bus.pending_rs), 32'd1);
    cycle();
    bus.wb_valid = 1'b0;
    #1;
    chk("t4_pend_after", 32'(bus.pending_rs), 32'd0);
    chk("t4_wb_data", bus.write_data, 32'h55);
    cycle();
    chk("t4_no_write", 32'(bus.reg_write), 32'd0);
    chk("t4_keep_data", bus.write_data, 32'h55);
    chk("t4_level", 32'(bus.fifo_level), 32'd0);
    bus.rs = 5'd0;

    // 5: address-0 traffic is a no-op on both paths
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hDEAD;
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd0; bus.lu_data = 32'hBEEF;
    #1;
    chk("t5_ready", 32'(bus.lu_ready), 32'd1);
    cycle();
    chk("t5_level", 32'(bus.fifo_level), 32'd0);
    chk("t5_we", 32'(bus.reg_write), 32'd0);
    idle_inputs();

    // 6: reset with three queued entries drops them all
    for (int i = 0; i < 3; i++) begin
      bus.wb_valid = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'(i);
      bus.lu_valid = 1'b1; bus.lu_addr = 5'(11 + i); bus.lu_data = 32'h200 + 32'(i);
      cycle();
    end
    idle_inputs();
    chk("t6_level_pre", 32'(bus.fifo_level), 32'd3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t6_level", 32'(bus.fifo_level), 32'd0);
    chk("t6_we", 32'(bus.reg_write), 32'd0);
    for (int i = 0; i < 5; i++) cycle();
    chk("t6_no_late_write", 32'(bus.reg_write), 32'd0);

    // Random traffic on a small address range to provoke kills, r0 and stalls
    for (int i = 0; i < 2000; i++) begin
      bus.wb_valid = ($urandom_range(0, 99) < 50);
      bus.wb_addr  = 5'($urandom_range(0, 7));
      bus.wb_data  = $urandom;
      bus.lu_valid = ($urandom_range(0, 99) < 60);
      bus.lu_addr  = 5'($urandom_range(0, 7));
      bus.lu_data  = $urandom;
      bus.rs       = 5'($urandom_range(0, 7));
      bus.rt       = 5'($urandom_range(0, 7));
      reset        = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 6; i++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
